regbus_arbiter: RTL
===================

// Module: regbus_arbiter
//
// PURPOSE
//   Shares one register-file port between NREQ requesters using round-robin arbitration.
//   The register-file port has these properties:
//     - write enable, address and write data are sampled on the rising clock edge;
//     - read data is registered, one cycle after the address.
//   Sits between bus masters (CPU, debug, DMA) and the register block.
//   Sequences one transaction at a time and returns a response to the granted requester.
//
// PARAMETERS
//   NREQ   2  number of requesters (2..4)
//   ADDRW  8  address width
//   DATAW  8  data width
//
// PORTS
//   i_clk        in   1           clock
//   i_rst        in   1           reset: synchronous, active-high
//   i_req_valid  in   NREQ        request valid, one bit per requester
//   o_req_ready  out  NREQ        request accepted (one-hot or zero)
//   i_req_we     in   NREQ        1 = write, 0 = read
//   i_req_addr   in   NREQ*ADDRW  packed request addresses; requester k in [k*ADDRW +: ADDRW]
//   i_req_data   in   NREQ*DATAW  packed write data; requester k in [k*DATAW +: DATAW]
//   o_rsp_valid  out  NREQ        one-cycle response pulse to the owning requester
//   o_rsp_data   out  DATAW       response data (shared by all requesters)
//   o_busy       out  1           FSM not in IDLE
//   o_reg_we     out  1           register-file write enable
//   o_reg_addr   out  ADDRW       register-file address
//   o_reg_data   out  DATAW       register-file write data
//   i_reg_data   in   DATAW       register-file registered read data
//
// BEHAVIOUR
//   FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE. Fixed, unconditional sequence outside IDLE.
//   IDLE
//     - Round-robin pick among i_req_valid, starting at (last+1) mod NREQ.
//     - o_req_ready = one-hot winner; combinational; only in IDLE, only if that requester is valid.
//     - On valid&ready: latch we/addr/data/owner, update last=owner, go to ISSUE.
//   ISSUE
//     - o_reg_addr = latched addr; o_reg_data = latched data.
//     - o_reg_we = latched we & ~i_rst; asserted only in this state.
//   CAPTURE
//     - o_reg_addr held.
//     - i_reg_data holds the register value sampled at the ISSUE edge.
//     - That value is registered into o_rsp_data.
//     - o_rsp_valid[owner] pulses in the next cycle.
//   Timing and data rules
//     - Latency: accept in cycle N; o_rsp_valid in cycle N+3.
//     - Max throughput: 1 transaction per 3 cycles.
//     - A new accept may coincide with the previous response pulse.
//     - Writes also respond; o_rsp_data = pre-write value (read-before-write).
//     - o_rsp_data holds its value until the next response.
//     - o_reg_addr/o_reg_data hold their last values in IDLE; o_reg_we = 0.
//   Requester obligations
//     - Hold valid, we, addr and data stable until ready.
//     - Dropping valid before ready withdraws the request.
//   Reset (sync)
//     - FSM -> IDLE; last = NREQ-1, so requester 0 wins first.
//     - Outputs: o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, o_reg_we=0, o_reg_addr=0, o_reg_data=0.
//     - Reset mid-transaction drops it silently, with no response pulse.
//     - A write in ISSUE concurrent with i_rst is suppressed.
//   Boundary cases
//     - Addresses are passed through unmodified; out-of-range decode belongs to the register block.
//     - A single active requester is granted back-to-back.
//
// CONFIGURATION
//   REGBUS_ARB_LOCK_EN defined:
//     - Adds port i_req_lock [NREQ].
//     - If an accepted request had lock=1, later IDLE arbitration grants only that owner.
//     - Others see ready=0 until the owner's next accepted request carries lock=0.
//     - That lock=0 request clears the lock after it is accepted.
//     - Reset clears the lock.
//   Not defined:
//     - No i_req_lock port; pure round-robin.
//
// TESTING
//   1. Write (req0): addr=2, data=0xA5 -> reg_we=1 for one cycle in N+1; rsp_valid[0] at N+3 with the old value.
//      Then read addr=2 -> rsp_data=0xA5.
//   2. Both valid, continuously, from reset -> grants 0,1,0,1; each rsp_valid goes only to its owner, 3 cycles after accept.
//   3. Only req1 valid for 4 transactions -> granted each time; accepts 3 cycles apart.
//   4. i_rst asserted in ISSUE of a write to addr=1 -> no reg_we; no rsp_valid; idle next cycle; addr=1 readback 0.
//   5. req0 drops valid before ready while req1 is being served -> req0 never accepted; no spurious rsp.
//   6. LOCK_EN: req0 lock=1, req1 valid throughout -> req0 granted twice.
//      req0 then sends lock=0 -> after that accept, req1 is granted.

Source files
------------

// File: rtl/regbus_arbiter.sv
// regbus_arbiter
//   Shares one register-file port between NREQ requesters with round-robin
//   arbitration. One transaction is in flight at a time and walks through
//   IDLE -> ISSUE -> CAPTURE -> IDLE; the owner gets a one-cycle response
//   pulse carrying the register value seen before any write (read-before-write).
//   Optional feature: define REGBUS_ARB_LOCK_EN to add i_req_lock, which lets
//   an owner keep exclusive access across several transactions.
module regbus_arbiter #(
  parameter int NREQ  = 2,
  parameter int ADDRW = 8,
  parameter int DATAW = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ-1:0]       i_req_we,
  input  logic [NREQ*ADDRW-1:0] i_req_addr,
  input  logic [NREQ*DATAW-1:0] i_req_data,
`ifdef REGBUS_ARB_LOCK_EN
  input  logic [NREQ-1:0]       i_req_lock,
`endif
  output logic [NREQ-1:0]       o_rsp_valid,
  output logic [DATAW-1:0]      o_rsp_data,
  output logic                  o_busy,
  output logic                  o_reg_we,
  output logic [ADDRW-1:0]      o_reg_addr,
  output logic [DATAW-1:0]      o_reg_data,
  input  logic [DATAW-1:0]      i_reg_data
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [IDXW-1:0]   last_r;
  logic [IDXW-1:0]   owner_r;
  logic              we_r;
  logic [ADDRW-1:0]  addr_r;
  logic [DATAW-1:0]  data_r;
  logic [NREQ-1:0]   rsp_valid_r;
  logic [DATAW-1:0]  rsp_data_r;
  logic [NREQ-1:0]   cand_s;
  logic [NREQ-1:0]   grant_s;
  logic [IDXW-1:0]   winner_s;
  logic              accept_s;

`ifdef REGBUS_ARB_LOCK_EN
  logic              lock_active_r;
  logic [IDXW-1:0]   lock_owner_r;
`endif

  // Round-robin pick among eligible requesters, starting one past the last owner
  always_comb begin
    logic [IDXW-1:0] idx;
    logic            found;
    logic            hit;
`ifdef REGBUS_ARB_LOCK_EN
    if (lock_active_r) begin
      cand_s = i_req_valid & (ONE_HOT0 << lock_owner_r);
    end else begin
      cand_s = i_req_valid;
    end
`else
    cand_s = i_req_valid;
`endif
    grant_s  = '0;
    winner_s = last_r;
    found    = 1'b0;
    idx      = '0;
    hit      = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx          = IDXW'((int'(last_r) + k) % NREQ);
      hit          = !found && cand_s[idx];
      grant_s[idx] = hit;
      winner_s     = hit ? idx : winner_s;
      found        = found | hit;
    end
  end

  // Ready is offered only in IDLE and never while reset is applied
  always_comb begin
    o_req_ready = '0;
    if ((state_r == IDLE) && !i_rst) begin
      o_req_ready = grant_s;
    end else begin
      o_req_ready = '0;
    end
  end

  assign accept_s = |o_req_ready;

  // Next-state logic: leave IDLE on accept, then a fixed two-step sequence
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE:   state_next_s = CAPTURE;
      CAPTURE: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Transaction latch, round-robin pointer and response register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_r      <= LAST_RST;
      owner_r     <= '0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else begin
      if (accept_s) begin
        owner_r <= winner_s;
        last_r  <= winner_s;
        we_r    <= i_req_we[winner_s];
        addr_r  <= i_req_addr[winner_s*ADDRW +: ADDRW];
        data_r  <= i_req_data[winner_s*DATAW +: DATAW];
      end
      if (state_r == CAPTURE) begin
        rsp_valid_r <= ONE_HOT0 << owner_r;
        rsp_data_r  <= i_reg_data;
      end else begin
        rsp_valid_r <= '0;
      end
    end
  end

`ifdef REGBUS_ARB_LOCK_EN
  // Lock tracking: an accepted lock=1 request pins arbitration to its owner
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_active_r <= 1'b0;
      lock_owner_r  <= '0;
    end else if (accept_s) begin
      lock_active_r <= i_req_lock[winner_s];
      lock_owner_r  <= winner_s;
    end
  end
`endif

  // The write strobe is cut by reset in the same cycle so a dropped write never lands
  assign o_reg_we    = (state_r == ISSUE) & we_r & ~i_rst;
  assign o_reg_addr  = addr_r;
  assign o_reg_data  = data_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_data  = rsp_data_r;
  assign o_busy      = (state_r != IDLE);

endmodule
